// File: rtl/mult_bist_pkg.sv
// rtl/mult_bist_pkg.sv - shared types, MISR constants and step function for mult_bist
package mult_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int CNT_WIDTH = 16;

  // Widest signature the shared step function supports; narrower MISRs truncate.
  localparam int SIG_MAX = 64;
  localparam logic [SIG_MAX-1:0] MISR_POLY = 64'h1021;
  localparam logic [SIG_MAX-1:0] MISR_SEED = '1;

  function automatic logic [SIG_MAX-1:0] misr_step(
    input logic [SIG_MAX-1:0] sig,
    input logic [SIG_MAX-1:0] data,
    input int                 width
  );
    logic [SIG_MAX-1:0] mask;
    logic               msb;
    mask = (64'd1 << width) - 64'd1;
    msb  = |(sig & (64'd1 << (width - 1)));
    return ((sig << 1) ^ (msb ? MISR_POLY : '0) ^ data) & mask;
  endfunction

endpackage

// File: rtl/mult_bist_misr.sv
// rtl/mult_bist_misr.sv - multiple-input signature register compacting DUT responses
module mult_bist_misr
  import mult_bist_pkg::*;
#(
  parameter int SIG_WIDTH  = 16,
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [SIG_WIDTH-1:0]  sig
);

  logic [SIG_WIDTH-1:0] sig_next;

  always_comb begin
    sig_next = SIG_WIDTH'(misr_step(SIG_MAX'(sig), SIG_MAX'(data), SIG_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sig <= MISR_SEED[SIG_WIDTH-1:0];
    end else if (enable) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/mult_bist.sv
// rtl/mult_bist.sv - BIST sequencer: counts operands into a combinational multiplier and signs its products
module mult_bist
  import mult_bist_pkg::*;
#(
  parameter int BIT_WIDTH   = 3,
  parameter int OUT_WIDTH   = 2 * BIT_WIDTH,
  parameter int SIG_WIDTH   = 16,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic [SIG_WIDTH-1:0] golden,
  output logic [BIT_WIDTH-1:0] dut_inp,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t               state;
  logic [CNT_WIDTH-1:0] remaining;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 last_hold;
  logic                 accept;
  logic                 absorb;
  logic [SIG_WIDTH-1:0] sig_next;

  assign last_hold = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  assign accept    = start && (state != ST_RUN);
  assign absorb    = (state == ST_RUN) && last_hold;

  // The verdict is taken on the same edge the final product is absorbed,
  // so compare against the signature the MISR is about to hold.
  always_comb begin
    sig_next = SIG_WIDTH'(misr_step(SIG_MAX'(signature), SIG_MAX'(dut_out), SIG_WIDTH));
  end

  mult_bist_misr #(
    .SIG_WIDTH (SIG_WIDTH),
    .DATA_WIDTH(OUT_WIDTH)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .enable(absorb),
    .data  (dut_out),
    .sig   (signature)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dut_inp   <= '0;
      remaining <= '0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (last_hold) begin
            hold_cnt  <= '0;
            dut_inp   <= dut_inp + BIT_WIDTH'(1);
            remaining <= remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == golden);
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          if (start) begin
            remaining <= cfg_count;
            dut_inp   <= '0;
            hold_cnt  <= '0;
            if (cfg_count == '0) begin
              // Nothing to apply: the seed itself is the signature.
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (MISR_SEED[SIG_WIDTH-1:0] == golden);
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mult_bist.md
MULT_BIST -- requirements
Module: mult_bist

Interface
REQ-001 The parameter BIT_WIDTH SHALL default to 3 and set the DUT operand width.
REQ-002 The parameter OUT_WIDTH SHALL default to 2*BIT_WIDTH and set the DUT product width.
REQ-003 The parameter SIG_WIDTH SHALL default to 16 and set the signature width, with OUT_WIDTH <= SIG_WIDTH.
REQ-004 The parameter HOLD_CYCLES SHALL default to 1 (minimum 1) and set the cycles each pattern is held before sampling.
REQ-005 The design SHALL use one clock; reset is synchronous and active-low.
REQ-006 Port clk SHALL be an input, 1 bit: the rising-edge clock.
REQ-007 Port rst_n SHALL be an input, 1 bit: the synchronous active-low reset.
REQ-008 Port start SHALL be an input, 1 bit: a single-cycle pulse requesting a test run.
REQ-009 Port cfg_count SHALL be an input, 16 bits: the number of patterns to apply, sampled on accepted start.
REQ-010 Port golden SHALL be an input, SIG_WIDTH bits: the expected signature, sampled on entry to DONE.
REQ-011 Port dut_inp SHALL be an output, BIT_WIDTH bits: the registered operand driven to the combinational DUT.
REQ-012 Port dut_out SHALL be an input, OUT_WIDTH bits: the DUT product, treated as raw bits.
REQ-013 Port busy SHALL be an output, 1 bit: high in RUN.
REQ-014 Port done SHALL be an output, 1 bit: high in DONE.
REQ-015 Port pass SHALL be an output, 1 bit: valid while done=1; high when signature equals golden.
REQ-016 Port signature SHALL be an output, SIG_WIDTH bits: the MISR contents.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL cause the following on the next edge:
- load cfg_count into the remaining counter;
- set dut_inp to 0;
- set signature to SEED = all-ones;
- clear the hold counter;
- enter RUN, or enter DONE directly if cfg_count=0.
REQ-019 In RUN, start SHALL be ignored.
REQ-020 In RUN, each pattern SHALL be held on dut_inp for exactly HOLD_CYCLES cycles.
REQ-021 On the edge ending the last hold cycle, the MISR SHALL absorb dut_out, dut_inp SHALL increment modulo 2^BIT_WIDTH, and the remaining count SHALL decrement.
REQ-022 The MISR update SHALL be: next = (sig << 1) XOR (sig[MSB] ? POLY : 0) XOR zero-extended dut_out, with POLY = 0x1021 for SIG_WIDTH=16.
REQ-023 When the remaining count reaches 0 on an absorb edge, the FSM SHALL enter DONE on that same edge.
REQ-024 A run of N patterns SHALL keep busy high for exactly N*HOLD_CYCLES cycles.
REQ-025 The pattern sequence SHALL be 0,1,...,2^BIT_WIDTH-1,0,... and SHALL wrap without a stall cycle.
REQ-026 In DONE, done=1 and pass SHALL be registered (signature == golden) on DONE entry.
REQ-027 In DONE, signature and dut_inp SHALL hold until the next accepted start.
REQ-028 In IDLE, dut_inp SHALL hold 0 and signature SHALL hold SEED.
REQ-029 A start accepted in DONE SHALL drop done and pass on the next edge.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force the following, regardless of state, including mid-RUN:
- state=IDLE;
- dut_inp=0;
- signature=SEED;
- busy=0, done=0, pass=0;
- all counters 0.
REQ-031 A start asserted in the same cycle as rst_n=0 SHALL be discarded.

Structure
REQ-032 Package mult_bist_pkg SHALL hold:
- the state enum;
- MISR POLY and SEED constants;
- the cfg_count width constant.
REQ-033 The MISR SHALL be a separate sub-module, mult_bist_misr, with inputs clk, rst_n, clear, enable and data, and output sig.
REQ-034 The FSM, the hold counter, the remaining counter and the pattern register SHALL reside in mult_bist.

Verification
REQ-035 The bench SHALL cover zero-count: cfg_count=0, start -> DONE after 1 edge, busy never high, signature=0xFFFF, pass=1 iff golden=0xFFFF.
REQ-036 The bench SHALL cover a single step: cfg_count=1, HOLD_CYCLES=1, dut_out forced 0 -> busy high 1 cycle, signature=0xEFDF, golden=0xEFDF gives pass=1, golden=0xEFDE gives pass=0.
REQ-037 The bench SHALL cover wrap-around: cfg_count=9, bench multiplier model on dut_inp -> dut_inp sequence 0..7,0, busy high 9 cycles, signature matching the bench reference MISR model.
REQ-038 The bench SHALL cover hold: HOLD_CYCLES=3, cfg_count=4 -> each dut_inp value stable 3 cycles, busy high 12 cycles, MISR absorbs only on cycles 3, 6, 9 and 12.
REQ-039 The bench SHALL cover start while busy: start pulsed mid-RUN -> no effect on count, pattern or signature.
REQ-040 The bench SHALL cover restart: start pulsed in DONE -> done=0 on the next edge.
REQ-041 The bench SHALL cover reset mid-run: rst_n=0 for 1 edge during RUN with start=1 -> IDLE, signature=0xFFFF, dut_inp=0, no run begins.
